// File: rtl/i2c_master.sv
// I2C register-access master: register write or burst read, no repeated start.
// Build option I2C_MASTER_NACK_ABORT_EN: a slave NACK jumps straight to STOP.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic [3:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_out_en
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP
  } state_t;

  state_t     state, state_n;
  logic [7:0] div_cnt;
  logic [1:0] ph;
  logic [2:0] bit_cnt;
  logic [3:0] rem;
  logic [7:0] tx, rx, reg_q, wdata_q;
  logic       rw_q, sda_s;
  logic       tick, bit_end, sample, last_bit;
  logic       accept, nack_stop;
  logic       is_tx, is_byte, is_ack;

  assign tick     = div_cnt == 8'(CLK_DIV - 1);
  assign bit_end  = tick && ph == 2'd3;
  assign sample   = tick && ph == 2'd2;
  assign last_bit = bit_end && bit_cnt == 3'd7;
  assign accept   = state == IDLE && start;
  assign is_tx    = state == ADDR || state == REG
                 || state == WDATA;
  assign is_byte  = is_tx || state == RDATA;
  assign is_ack   = state == ADDR_ACK || state == REG_ACK
                 || state == WDATA_ACK;
  assign busy     = state != IDLE;

`ifdef I2C_MASTER_NACK_ABORT_EN
  assign nack_stop = sda_s;
`else
  assign nack_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (start) state_n = START;
      START:     if (bit_end) state_n = ADDR;
      ADDR:      if (last_bit) state_n = ADDR_ACK;
      ADDR_ACK:  if (bit_end) state_n = nack_stop ? STOP : REG;
      REG:       if (last_bit) state_n = REG_ACK;
      REG_ACK:
        if (bit_end)
          state_n = nack_stop ? STOP : (rw_q ? RDATA : WDATA);
      WDATA:     if (last_bit) state_n = WDATA_ACK;
      WDATA_ACK: if (bit_end) state_n = STOP;
      RDATA:     if (last_bit) state_n = RDATA_ACK;
      RDATA_ACK:
        if (bit_end) state_n = (rem <= 4'd1) ? STOP : RDATA;
      STOP:      if (bit_end) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bus pins decode from state and quarter; shifts land on quarter-0 edges.
  always_comb begin
    SCL        = 1'b1;
    SDA_out_en = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE:  ;
      START: SDA_out_en = ~ph[1];
      ADDR, REG, WDATA: begin
        SCL        = ph[1];
        SDA_out_en = tx[7];
      end
      ADDR_ACK, REG_ACK, WDATA_ACK, RDATA: SCL = ph[1];
      RDATA_ACK: begin
        SCL        = ph[1];
        SDA_out_en = rem <= 4'd1;
      end
      STOP: begin
        SCL        = ph[1];
        SDA_out_en = 1'b0;
        done       = bit_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      ph          <= '0;
      bit_cnt     <= '0;
      rem         <= '0;
      tx          <= '0;
      rx          <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      sda_s       <= 1'b1;
      ack_err     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 8'd1;
      if (state == IDLE) ph <= '0;
      else if (tick) ph <= ph + 2'd1;
      if (accept) begin
        tx      <= {dev_addr, rw};
        rw_q    <= rw;
        reg_q   <= reg_addr;
        wdata_q <= wdata;
        rem     <= (rd_len == 4'd0) ? 4'd1 : rd_len;
        ack_err <= 1'b0;
        bit_cnt <= '0;
      end
      if (sample) begin
        sda_s <= SDA_in;
        if (state == RDATA) rx <= {rx[6:0], SDA_in};
      end
      if (bit_end) begin
        bit_cnt <= is_byte ? bit_cnt + 3'd1 : 3'd0;
        unique case (1'b1)
          is_tx:              tx <= {tx[6:0], 1'b0};
          state == ADDR_ACK:  tx <= reg_q;
          state == REG_ACK:   tx <= wdata_q;
          default: ;
        endcase
        if (is_ack && sda_s) ack_err <= 1'b1;
        if (state == RDATA && bit_cnt == 3'd7) begin
          rdata       <= rx;
          rdata_valid <= 1'b1;
        end
        if (state == RDATA_ACK && rem != 4'd0)
          rem <= rem - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: slave model at 0x42 plus bus sniffer.
// Extra instances at CLK_DIV 2 and 255 check SCL timing.
module tb_i2c_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wdata = '0;
  logic [3:0] rd_len = '0;
  logic       busy, done, ack_err, rdata_valid;
  logic [7:0] rdata;
  logic       SCL, SDA_out_en, SDA_in;
  logic       sda_drv = 1'b1;

  assign SDA_in = SDA_out_en & sda_drv;

  i2c_master #(.CLK_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wdata(wdata), .rd_len(rd_len), .busy(busy),
    .done(done), .ack_err(ack_err), .rdata(rdata),
    .rdata_valid(rdata_valid), .SCL(SCL),
    .SDA_in(SDA_in), .SDA_out_en(SDA_out_en)
  );

  logic       start2 = 1'b0, start5 = 1'b0;
  logic       busy2, done2, err2, rv2, scl2, sda2;
  logic       busy5, done5, err5, rv5, scl5, sda5;
  logic [7:0] rd2, rd5;

  i2c_master #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .reset(reset), .start(start2), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wdata(wdata), .rd_len(rd_len), .busy(busy2),
    .done(done2), .ack_err(err2), .rdata(rd2),
    .rdata_valid(rv2), .SCL(scl2),
    .SDA_in(1'b0), .SDA_out_en(sda2)
  );

  i2c_master #(.CLK_DIV(255)) u_div255 (
    .clk(clk), .reset(reset), .start(start5), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wdata(wdata), .rd_len(rd_len), .busy(busy5),
    .done(done5), .ack_err(err5), .rdata(rd5),
    .rdata_valid(rv5), .SCL(scl5),
    .SDA_in(1'b0), .SDA_out_en(sda5)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h20:   return 8'h11;
      8'h21:   return 8'h22;
      8'h22:   return 8'h33;
      default: return ~a;
    endcase
  endfunction

  // Slave at 0x42 and bus sniffer, evaluated mid-cycle.
  logic       p_scl = 1'b1, p_sda = 1'b1, sda_b;
  int         sbit = 0, sbyte = 0;
  logic [7:0] sh = '0, ptr = '0, rb = '0;
  logic [7:0] wr_reg = '0, wr_data = '0;
  logic       addressed = 1'b0, srd = 1'b0, rstop = 1'b0;
  logic [7:0] blog[$];
  logic       alog[$];
  logic [7:0] rlog[$];
  int         n_start = 0, n_stop = 0, n_done = 0;

  always @(negedge clk) begin
    sda_b = SDA_in;
    if (rdata_valid) rlog.push_back(rdata);
    if (done) n_done++;
    if (p_scl && SCL && sda_b != p_sda) begin
      if (!sda_b) begin
        n_start++;
        sbit = 0;
        sbyte = 0;
        addressed = 1'b0;
        srd = 1'b0;
        rstop = 1'b0;
      end else begin
        n_stop++;
      end
      sda_drv = 1'b1;
    end else if (!p_scl && SCL) begin
      if (sbit < 8) begin
        sh = {sh[6:0], sda_b};
      end else begin
        alog.push_back(sda_b);
        if (addressed && srd && sbyte >= 2 && sda_b)
          rstop = 1'b1;
      end
      sbit++;
    end else if (p_scl && !SCL) begin
      if (sbit == 8) begin
        blog.push_back(sh);
        sda_drv = 1'b1;
        if (sbyte == 0) begin
          addressed = sh[7:1] == 7'h42;
          srd = sh[0];
          sda_drv = !addressed;
        end else if (!(addressed && srd && sbyte >= 2)) begin
          if (sbyte == 1) ptr = sh;
          else if (addressed) begin
            wr_reg = ptr;
            wr_data = sh;
          end
          sda_drv = !addressed;
        end
      end else if (sbit == 9) begin
        sbit = 0;
        sbyte++;
        rb = rom(ptr + 8'(sbyte - 2));
        sda_drv = 1'b1;
        if (addressed && srd && sbyte >= 2 && !rstop)
          sda_drv = rb[7];
      end else if (addressed && srd && sbyte >= 2 && !rstop) begin
        sda_drv = rb[7 - sbit];
      end
    end
    p_scl = SCL;
    p_sda = sda_b;
  end

  // Timing monitors for the fast and slow instances.
  logic p2s = 1'b1, p2d = 1'b1, p5s = 1'b1, p5d = 1'b1;
  int   r2 = 0, r5 = 0, per2 = 0, per5 = 0;
  int   ev2 = 0, ev5 = 0, nd2 = 0, nd5 = 0;

  always @(negedge clk) begin
    if (done2) nd2++;
    if (done5) nd5++;
    if (scl2 && !p2s) begin
      per2 = cyc - r2;
      r2 = cyc;
    end
    if (scl5 && !p5s) begin
      per5 = cyc - r5;
      r5 = cyc;
    end
    if (scl2 && p2s && sda2 != p2d) ev2++;
    if (scl5 && p5s && sda5 != p5d) ev5++;
    p2s = scl2;
    p2d = sda2;
    p5s = scl5;
    p5d = sda5;
  end

  task automatic pulse(input logic r, input logic [6:0] d,
                       input logic [7:0] ra, input logic [7:0] wd,
                       input logic [3:0] n);
    @(posedge clk); #1;
    rw = r;
    dev_addr = d;
    reg_addr = ra;
    wdata = wd;
    rd_len = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = n_done > d0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({SCL, SDA_out_en, busy, done, ack_err, rdata_valid, rdata}
        !== {6'b110000, 8'h00}) begin
      errors++;
      $display("FAIL reset: got %b/%h want 110000/00",
               {SCL, SDA_out_en, busy, done, ack_err, rdata_valid}, rdata);
    end
    checks++;
    if ({scl2, sda2, busy2, scl5, sda5, busy5} !== 6'b110110) begin
      errors++;
      $display("FAIL reset_div: got %b want 110110",
               {scl2, sda2, busy2, scl5, sda5, busy5});
    end
    reset = 1'b0;
  endtask

  task automatic test_write();
    int b0, a0, d0, s0, p0;
    bit ok;
    logic [39:0] gb;
    logic [7:0] ga;
    b0 = blog.size(); a0 = alog.size();
    d0 = n_done; s0 = n_start; p0 = n_stop;
    pulse(1'b0, 7'h42, 8'h10, 8'hA5, 4'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy: got %b want 1", busy);
    end
    wait_done(d0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wr_done: no done pulse within budget");
    end
    gb = '0;
    for (int i = b0; i < blog.size(); i++) gb = {gb[31:0], blog[i]};
    ga = '0;
    for (int i = a0; i < alog.size(); i++) ga = {ga[6:0], alog[i]};
    checks++;
    if (gb !== 40'h84_10_A5) begin
      errors++;
      $display("FAIL wr_bytes: got %h want 8410a5", gb);
    end
    checks++;
    if ({alog.size() - a0, ga} !== {32'd3, 8'h00}) begin
      errors++;
      $display("FAIL wr_acks: got n=%0d %b want n=3 000",
               alog.size() - a0, ga);
    end
    checks++;
    if ({ack_err, busy, wr_reg, wr_data} !== {2'b00, 16'h10A5}) begin
      errors++;
      $display("FAIL wr_state: got err=%b busy=%b reg=%h data=%h want 0 0 10 a5",
               ack_err, busy, wr_reg, wr_data);
    end
    checks++;
    if ({n_done - d0, n_start - s0, n_stop - p0} !== {32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL wr_frame: got done=%0d start=%0d stop=%0d want 1 1 1",
               n_done - d0, n_start - s0, n_stop - p0);
    end
  endtask

  task automatic test_read(input logic [7:0] ra, input logic [3:0] n,
                           input logic [39:0] eb, input int nb,
                           input logic [7:0] ea, input logic [23:0] er,
                           input int nr);
    int b0, a0, r0, d0;
    bit ok;
    logic [39:0] gb;
    logic [7:0] ga;
    logic [23:0] gr;
    b0 = blog.size(); a0 = alog.size();
    r0 = rlog.size(); d0 = n_done;
    pulse(1'b1, 7'h42, ra, 8'h00, n);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rd_done: no done pulse within budget");
    end
    gb = '0;
    for (int i = b0; i < blog.size(); i++) gb = {gb[31:0], blog[i]};
    ga = '0;
    for (int i = a0; i < alog.size(); i++) ga = {ga[6:0], alog[i]};
    gr = '0;
    for (int i = r0; i < rlog.size(); i++) gr = {gr[15:0], rlog[i]};
    checks++;
    if ({blog.size() - b0, gb} !== {nb, eb}) begin
      errors++;
      $display("FAIL rd_bytes: got n=%0d %h want n=%0d %h",
               blog.size() - b0, gb, nb, eb);
    end
    checks++;
    if (ga !== ea) begin
      errors++;
      $display("FAIL rd_acks: got %b want %b", ga, ea);
    end
    checks++;
    if ({rlog.size() - r0, gr} !== {nr, er}) begin
      errors++;
      $display("FAIL rd_data: got n=%0d %h want n=%0d %h",
               rlog.size() - r0, gr, nr, er);
    end
    checks++;
    if ({ack_err, rdata} !== {1'b0, er[7:0]}) begin
      errors++;
      $display("FAIL rd_out: got err=%b rdata=%h want 0 %h",
               ack_err, rdata, er[7:0]);
    end
  endtask

  task automatic test_nack();
    int b0, a0, d0;
    bit ok;
    logic [39:0] gb;
    logic [7:0] ga;
    b0 = blog.size(); a0 = alog.size(); d0 = n_done;
    pulse(1'b0, 7'h43, 8'h10, 8'h5A, 4'd0);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nack_done: no done pulse within budget");
    end
    gb = '0;
    for (int i = b0; i < blog.size(); i++) gb = {gb[31:0], blog[i]};
    ga = '0;
    for (int i = a0; i < alog.size(); i++) ga = {ga[6:0], alog[i]};
    checks++;
`ifdef I2C_MASTER_NACK_ABORT_EN
    if ({gb, ga} !== {40'h86, 8'h01}) begin
      errors++;
      $display("FAIL nack_bus: got %h acks %b want 86 1", gb, ga);
    end
`else
    if ({gb, ga} !== {40'h86_10_5A, 8'h07}) begin
      errors++;
      $display("FAIL nack_bus: got %h acks %b want 86105a 111", gb, ga);
    end
`endif
    checks++;
    if (ack_err !== 1'b1) begin
      errors++;
      $display("FAIL nack_err: got %b want 1", ack_err);
    end
    d0 = n_done;
    pulse(1'b0, 7'h42, 8'h30, 8'h66, 4'd0);
    checks++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("FAIL nack_clear: got %b want 0", ack_err);
    end
    wait_done(d0, ok);
    checks++;
    if ({ok, ack_err, wr_reg, wr_data} !== {2'b10, 16'h3066}) begin
      errors++;
      $display("FAIL nack_next: got ok=%b err=%b %h %h want 1 0 30 66",
               ok, ack_err, wr_reg, wr_data);
    end
  endtask

  task automatic test_mid_reset();
    int d0, p0;
    bit ok;
    d0 = n_done; p0 = n_stop;
    pulse(1'b0, 7'h42, 8'h55, 8'h77, 4'd0);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = sbyte == 1 && sbit == 4;
    end
    for (int i = 0; i < 100 && SCL; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({ok, SCL, busy} !== 3'b101) begin
      errors++;
      $display("FAIL mrst_reach: got ok/scl/busy %b want 101",
               {ok, SCL, busy});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({SCL, SDA_out_en, busy, done, rdata} !== {4'b1100, 8'h00}) begin
      errors++;
      $display("FAIL mrst_now: got %b/%h want 1100/00",
               {SCL, SDA_out_en, busy, done}, rdata);
    end
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if ({n_done - d0, n_stop - p0} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL mrst_quiet: got done=%0d stop=%0d want 0 0",
               n_done - d0, n_stop - p0);
    end
  endtask

  task automatic test_back_to_back();
    int b0, d0, s0;
    bit ok;
    logic [39:0] gb;
    b0 = blog.size(); d0 = n_done; s0 = n_start;
    pulse(1'b0, 7'h42, 8'h11, 8'h3C, 4'd0);
    repeat (10) @(posedge clk);
    pulse(1'b1, 7'h42, 8'h12, 8'hC3, 4'd2);
    wait_done(d0, ok);
    repeat (300) @(posedge clk);
    #1;
    gb = '0;
    for (int i = b0; i < blog.size(); i++) gb = {gb[31:0], blog[i]};
    checks++;
    if ({ok, gb} !== {1'b1, 40'h84_11_3C}) begin
      errors++;
      $display("FAIL b2b_bytes: got ok=%b %h want 1 84113c", ok, gb);
    end
    checks++;
    if ({n_done - d0, n_start - s0, busy} !== {32'd1, 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_count: got done=%0d start=%0d busy=%b want 1 1 0",
               n_done - d0, n_start - s0, busy);
    end
  endtask

  task automatic test_div();
    int d2, d5, e2, e5;
    bit ok;
    d2 = nd2; d5 = nd5; e2 = ev2; e5 = ev5;
    @(posedge clk); #1;
    rw = 1'b0;
    dev_addr = 7'h42;
    reg_addr = 8'h10;
    wdata = 8'hA5;
    start2 = 1'b1;
    start5 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    start5 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = nd2 > d2 && nd5 > d5;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({ok, nd2 - d2, nd5 - d5} !== {1'b1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL div_done: got ok=%b %0d %0d want 1 1 1",
               ok, nd2 - d2, nd5 - d5);
    end
    checks++;
    if ({per2, per5} !== {32'd8, 32'd1020}) begin
      errors++;
      $display("FAIL div_period: got %0d %0d want 8 1020", per2, per5);
    end
    checks++;
    if ({ev2 - e2, ev5 - e5} !== {32'd2, 32'd2}) begin
      errors++;
      $display("FAIL div_sda_hi: got %0d %0d edges want 2 2",
               ev2 - e2, ev5 - e5);
    end
    checks++;
    if ({err2, err5, busy2, busy5} !== 4'b0000) begin
      errors++;
      $display("FAIL div_state: got %b want 0000",
               {err2, err5, busy2, busy5});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(8'h20, 4'd3, 40'h85_20_11_22_33, 5,
              8'b00001, 24'h11_22_33, 3);
    test_read(8'h21, 4'd0, 40'h85_21_22, 3,
              8'b001, 24'h22, 1);
    test_nack();
    test_mid_reset();
    test_back_to_back();
    test_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period, legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle transaction request, accepted only in IDLE.
REQ-005 SHALL have port rw, input, 1 bit: 0 = register write, 1 = register read; sampled with start.
REQ-006 SHALL have port dev_addr, input, 7 bits: target address; sampled with start.
REQ-007 SHALL have port reg_addr, input, 8 bits: register index; sampled with start.
REQ-008 SHALL have port wdata, input, 8 bits: write byte; sampled with start.
REQ-009 SHALL have port rd_len, input, 4 bits: bytes to read (0 treated as 1); sampled with start.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when STOP completes.
REQ-012 SHALL have port ack_err, output, 1 bit: set on any NACK in a slave-ACK slot; cleared on the next accepted start.
REQ-013 SHALL have port rdata, output, 8 bits: last received read byte.
REQ-014 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse when rdata updates.
REQ-015 SHALL have port SCL, output, 1 bit: bus clock, idle high.
REQ-016 SHALL have port SDA_in, input, 1 bit: sampled bus data.
REQ-017 SHALL have port SDA_out_en, output, 1 bit: 0 = pull SDA low, 1 = release; idle 1.

Function
REQ-018 SHALL use states IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP.
REQ-019 SHALL form one SCL bit period as 4 quarters of CLK_DIV cycles: SCL low for quarters 0-1 and high for quarters 2-3; SDA_out_en changes only at the start of quarter 0.
REQ-020 SHALL sample SDA_in at the start of quarter 3 (SCL stable high).
REQ-021 SHALL execute START with SCL high: SDA_out_en falls at the half-period point, then SCL falls one half-period later.
REQ-022 SHALL transmit {dev_addr, rw} in ADDR, MSB first; reg_addr in REG; wdata in WDATA (write only).
REQ-023 SHALL release SDA during each *_ACK slot; a sampled 1 is a NACK and sets ack_err.
REQ-024 Transition REG_ACK SHALL go to WDATA when rw=0 and to RDATA when rw=1; there is no repeated start.
REQ-025 SHALL shift 8 bits MSB first in RDATA, then update rdata and pulse rdata_valid at the end of bit 8.
REQ-026 SHALL drive ACK (0) in RDATA_ACK while bytes remain and NACK (1) on the final byte, then enter STOP.
REQ-027 SHALL execute STOP with SDA held low while SCL rises, then release SDA one half-period later; done pulses and the FSM returns to IDLE.
REQ-028 SHALL ignore start while busy=1; it has no side effects.
REQ-029 SHALL keep the bit counter 3 bits wide and the remaining-bytes counter 4 bits wide, with no wrap past 0.

Reset
REQ-030 On reset=1, the block SHALL on the next clk edge set state IDLE, SCL=1, SDA_out_en=1, busy=0, done=0, ack_err=0, rdata=0x00, rdata_valid=0, and clear all counters.
REQ-031 Reset mid-transaction SHALL abort immediately with no STOP generated and no done pulse.

Configuration
REQ-032 With macro I2C_MASTER_NACK_ABORT_EN defined, a NACK in ADDR_ACK, REG_ACK or WDATA_ACK SHALL go directly to STOP; the remaining bytes are skipped.
REQ-033 Without I2C_MASTER_NACK_ABORT_EN, a NACK SHALL only set ack_err and the transaction SHALL run to completion.

Verification
REQ-034 Write: dev 0x42, reg 0x10, wdata 0xA5, slave ACKs -> bus bytes 0x84, 0x10, 0xA5, STOP, done=1, ack_err=0.
REQ-035 Read: dev 0x42, reg 0x20, rd_len 3, slave memory 0x11/0x22/0x33 -> 3 rdata_valid pulses with 0x11, 0x22, 0x33; master ACK, ACK, NACK; STOP.
REQ-036 Wrong address: dev 0x43 with a 0x42 slave -> ack_err=1; with the macro, STOP right after ADDR_ACK; without it, all bytes are sent.
REQ-037 Reset asserted during REG bit 4 -> next cycle SCL=1, SDA_out_en=1, busy=0, no done pulse.
REQ-038 Second start pulse during a busy write -> ignored; a single transaction appears on the bus with a single done pulse.
REQ-039 CLK_DIV=2 and CLK_DIV=255 -> SCL period of 8 and 1020 clk cycles respectively, and SDA stable during SCL high except at START/STOP.
